timing_sensor_bank: RTL and testbench

Parametrised successor to the fixed 32-channel timing-sensor bank. It instantiates N_SENS delay-line sensor cells; each cell is either a plain tsensor or a tsensor_inv, selected per channel by INV_MASK. Raw alarms are synchronised, masked, latched sticky, and counted. An interrupt is raised when the alarm-cycle count reaches a programmable threshold. The block sits between the sensor fabric and the coprocessor register interface.

---
 rtl/timing_sensor_bank.sv | 204 ++++++++++++++++++++
 tb/tb_timing_sensor_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timing_sensor_bank.sv
// Timing-sensor bank: N_SENS delay-line cells feeding a synchronised, masked,
// sticky alarm path with a saturating alarm-cycle counter and threshold interrupt.

module tsensor #(
    parameter int S_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [S_W-1:0] s,
    output logic           alarm
);
    // Flags a cycle in which the sensed bus moved since the previous edge.
    logic [S_W-1:0] s_q, s_d;
    logic           alarm_q, alarm_d;

    always_comb begin
        s_d     = s;
        alarm_d = |(s ^ s_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            alarm_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
endmodule

module tsensor_inv #(
    parameter int S_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [S_W-1:0] s,
    output logic           alarm
);
    // Inverted sense: flags a cycle in which the sensed bus failed to move.
    logic [S_W-1:0] s_q, s_d;
    logic           alarm_q, alarm_d;

    always_comb begin
        s_d     = s;
        alarm_d = ~|(s ^ s_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            alarm_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
endmodule

// state  | meaning
// ARMED  | irq low, waiting for alarm_count to reach a non-zero threshold
// ALERT  | irq high, held until clear or rst
module timing_sensor_bank #(
    parameter int          N_SENS   = 32,
    parameter int          S_W      = 32,
    parameter logic [63:0] INV_MASK = 64'h00000000FFFF0000,
    parameter int          CNT_W    = 16,
    parameter int          IDX_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [S_W-1:0]    s,
    input  logic [N_SENS-1:0] en_mask,
    input  logic              test_mode,
    input  logic [N_SENS-1:0] test_alarm,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              clear,
    output logic [N_SENS-1:0] alarm_sticky,
    output logic [CNT_W-1:0]  alarm_count,
    output logic [IDX_W-1:0]  first_ch,
    output logic              first_valid,
    output logic              irq
);
    typedef enum logic {
        ARMED = 1'b0,
        ALERT = 1'b1
    } state_t;

    logic [N_SENS-1:0] cell_alarm;
    logic [N_SENS-1:0] raw;

    for (genvar i = 0; i < N_SENS; i++) begin : g_cell
        if (INV_MASK[i]) begin : g_inv
            tsensor_inv #(.S_W(S_W)) u_cell (
                .clk   (clk),
                .rst   (rst),
                .s     (s),
                .alarm (cell_alarm[i])
            );
        end else begin : g_plain
            tsensor #(.S_W(S_W)) u_cell (
                .clk   (clk),
                .rst   (rst),
                .s     (s),
                .alarm (cell_alarm[i])
            );
        end
    end

    assign raw = test_mode ? test_alarm : cell_alarm;

    logic [N_SENS-1:0] sync1_q, sync1_d;
    logic [N_SENS-1:0] sync2_q, sync2_d;
    logic [N_SENS-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  first_q, first_d;
    logic              fvalid_q, fvalid_d;
    state_t            state_q, state_d;

    logic [N_SENS-1:0] sample;
    logic [CNT_W-1:0]  count_next;
    logic [IDX_W-1:0]  low_idx;

    always_comb begin
        sample = sync2_q & en_mask;

        count_next = count_q;
        if (sample != '0 && count_q != {CNT_W{1'b1}}) begin
            count_next = count_q + CNT_W'(1);
        end

        // Scan high to low so the lowest set bit wins.
        low_idx = '0;
        for (int i = N_SENS - 1; i >= 0; i--) begin
            if (sample[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        sticky_d = sticky_q | sample;
        count_d  = count_next;
        first_d  = first_q;
        fvalid_d = fvalid_q;
        state_d  = state_q;

        if (!fvalid_q && sample != '0) begin
            first_d  = low_idx;
            fvalid_d = 1'b1;
        end

        case (state_q)
            ARMED: begin
                if (threshold != '0 && count_next >= threshold) begin
                    state_d = ALERT;
                end
            end
            ALERT: state_d = ALERT;
            default: state_d = ARMED;
        endcase

        // Clear wins over a coincident sample; sync stages keep running.
        if (clear) begin
            sticky_d = '0;
            count_d  = '0;
            first_d  = '0;
            fvalid_d = 1'b0;
            state_d  = ARMED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sticky_q <= '0;
            count_q  <= '0;
            first_q  <= '0;
            fvalid_q <= 1'b0;
            state_q  <= ARMED;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            first_q  <= first_d;
            fvalid_q <= fvalid_d;
            state_q  <= state_d;
        end
    end

    assign alarm_sticky = sticky_q;
    assign alarm_count  = count_q;
    assign first_ch     = first_q;
    assign first_valid  = fvalid_q;
    assign irq          = (state_q == ALERT);
endmodule

// File: tb/tb_timing_sensor_bank.sv
// Bench for timing_sensor_bank: a 16-bit and a 4-bit counter instance share
// stimulus and are checked every cycle against a behavioural model.
module tb_timing_sensor_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s;
    logic [31:0] en_mask;
    logic        test_mode;
    logic [31:0] test_alarm;
    logic [15:0] thr16;
    logic [3:0]  thr4;
    logic        clear;

    logic [31:0] sticky16, sticky4;
    logic [15:0] count16;
    logic [3:0]  count4;
    logic [5:0]  first16, first4;
    logic        fv16, fv4, irq16, irq4;

    int n_checks = 0;
    int n_fail   = 0;

    assign thr4 = thr16[3:0];

    always #5 clk = ~clk;

    timing_sensor_bank u16 (
        .clk(clk), .rst(rst), .s(s), .en_mask(en_mask), .test_mode(test_mode),
        .test_alarm(test_alarm), .threshold(thr16), .clear(clear),
        .alarm_sticky(sticky16), .alarm_count(count16), .first_ch(first16),
        .first_valid(fv16), .irq(irq16)
    );

    timing_sensor_bank #(.CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .s(s), .en_mask(en_mask), .test_mode(test_mode),
        .test_alarm(test_alarm), .threshold(thr4), .clear(clear),
        .alarm_sticky(sticky4), .alarm_count(count4), .first_ch(first4),
        .first_valid(fv4), .irq(irq4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw alarms reach the sample point two edges later.
    logic [31:0] raw_hist [2];
    logic [31:0] m_sticky [2];
    int          m_cnt    [2];
    int          m_first  [2];
    bit          m_fv     [2];
    bit          m_irq    [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            raw_hist[k] = '0; m_sticky[k] = '0; m_cnt[k] = 0;
            m_first[k] = 0; m_fv[k] = 0; m_irq[k] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    raw_hist[k] = '0; m_sticky[k] = '0; m_cnt[k] = 0;
                    m_first[k] = 0; m_fv[k] = 0; m_irq[k] = 0;
                end
            end else begin
                logic [31:0] smp;
                smp = raw_hist[1] & en_mask;
                for (int k = 0; k < 2; k++) begin
                    int thr, cmax;
                    thr  = (k == 0) ? int'(thr16) : int'(thr4);
                    cmax = (k == 0) ? 65535 : 15;
                    if (clear) begin
                        m_sticky[k] = '0; m_cnt[k] = 0; m_first[k] = 0;
                        m_fv[k] = 0; m_irq[k] = 0;
                    end else begin
                        m_sticky[k] = m_sticky[k] | smp;
                        if (smp != 0 && m_cnt[k] < cmax) m_cnt[k]++;
                        if (!m_fv[k] && smp != 0) begin
                            m_fv[k] = 1;
                            for (int b = 31; b >= 0; b--) if (smp[b]) m_first[k] = b;
                        end
                        if (thr != 0 && m_cnt[k] >= thr) m_irq[k] = 1;
                    end
                end
                raw_hist[1] = raw_hist[0];
                raw_hist[0] = test_alarm;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("m16_sticky", sticky16, m_sticky[0]);
                chk("m16_count",  count16,  m_cnt[0]);
                chk("m16_first",  first16,  m_first[0]);
                chk("m16_fv",     fv16,     m_fv[0]);
                chk("m16_irq",    irq16,    m_irq[0]);
                chk("m4_sticky",  sticky4,  m_sticky[1]);
                chk("m4_count",   count4,   m_cnt[1]);
                chk("m4_first",   first4,   m_first[1]);
                chk("m4_fv",      fv4,      m_fv[1]);
                chk("m4_irq",     irq4,     m_irq[1]);
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] v);
        test_alarm = v;
        tick();
        test_alarm = '0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; s = '0; en_mask = '1; test_mode = 1'b1;
        test_alarm = '0; thr16 = 16'd3; clear = 1'b0;
        #2;
        chk("reset_sticky", sticky16, 0);
        chk("reset_count",  count16,  0);
        chk("reset_irq",    irq16,    0);
        tick();
        rst = 1'b0;
        tick(3);

        // Inject and capture first channel
        pulse(32'h0000_0110);
        chk("inj_sticky", sticky16, 32'h110);
        chk("inj_count",  count16,  1);
        chk("inj_first",  first16,  4);
        chk("inj_fv",     fv16,     1);
        chk("inj_irq",    irq16,    0);

        // Reach threshold with pulses on bit 31
        pulse(32'h8000_0000);
        chk("thr_count2", count16, 2);
        chk("thr_irq2",   irq16,   0);
        pulse(32'h8000_0000);
        chk("thr_count3", count16, 3);
        chk("thr_irq3",   irq16,   1);
        chk("thr_sticky", sticky16, 32'h8000_0110);
        chk("thr_first",  first16,  4);
        pulse(32'h8000_0000);
        chk("thr_count4", count16, 4);
        chk("thr_irq4",   irq16,   1);
        pulse(32'h8000_0000);
        chk("alert_count5", count16, 5);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("arst_sticky", sticky16, 0);
        chk("arst_count",  count16,  0);
        chk("arst_first",  first16,  0);
        chk("arst_fv",     fv16,     0);
        chk("arst_irq",    irq16,    0);
        tick();
        rst = 1'b0;
        tick(2);
        chk("post_rst_irq", irq16, 0);

        // Masked channel ignored
        en_mask = 32'hFFFF_FFFE;
        test_alarm = 32'h1;
        tick(10);
        test_alarm = '0;
        tick(3);
        chk("mask_sticky", sticky16, 0);
        chk("mask_count",  count16,  0);
        chk("mask_fv",     fv16,     0);
        en_mask = '1;
        tick();

        // Clear collides with a sample
        test_alarm = 32'h8;
        tick();
        test_alarm = 32'h2;
        tick();
        test_alarm = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_sticky", sticky16, 0);
        chk("clr_count",  count16,  0);
        chk("clr_fv",     fv16,     0);
        tick();
        chk("clr_next_count", count16, 1);
        chk("clr_next_first", first16, 1);
        chk("clr_next_sticky", sticky16, 32'h2);
        tick(2);

        // Saturation with irq disabled
        thr16 = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        test_alarm = '1;
        tick(20);
        test_alarm = '0;
        tick(3);
        chk("sat_count4",  count4,  15);
        chk("sat_irq4",    irq4,    0);
        chk("sat_count16", count16, 20);
        chk("sat_irq16",   irq16,   0);

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            s = $urandom;
            test_alarm = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
            if ($urandom_range(0, 15) == 0) en_mask = $urandom | $urandom;
            if ($urandom_range(0, 20) == 0) thr16 = 16'($urandom_range(0, 24));
            clear = ($urandom_range(0, 40) == 0);
            tick();
        end
        clear = 1'b0;
        test_alarm = '0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
